shadowmask_loader: RTL and testbench

- Upstream command source for the shadowmask stage.
- On request, reads a stored mask definition from a slot-organised 16-bit ROM. Replays it as the mode, vmax, hmax and LUT write command stream that the shadowmask consumes on its `cmd_wr`/`cmd_in` inputs.
- Also re-issues the mode command alone when runtime mask settings change.
- Runs in the `clk_sys` domain, same clock as the shadowmask command port.

---
 rtl/shadowmask_loader_if.sv | 32 +++
 rtl/shadowmask_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_shadowmask_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shadowmask_loader_if.sv
// Host request, mask ROM and shadowmask command-port signals of the shadowmask loader.
// Strobes (load_req, cfg_update, rom_rd, cmd_wr, done) are single-cycle pulses; there is no backpressure.
interface shadowmask_loader_if #(
   parameter int SLOT_W     = 3,
   parameter int SLOT_SHIFT = 9
);
   logic                         load_req;
   logic [SLOT_W-1:0]            load_slot;
   logic                         cfg_update;
   logic                         mask_enable;
   logic                         mask_rotate;
   logic                         mask_2x;
   logic [SLOT_W+SLOT_SHIFT-1:0] rom_addr;
   logic                         rom_rd;
   logic [15:0]                  rom_data;
   logic                         cmd_wr;
   logic [15:0]                  cmd_out;
   logic                         busy;
   logic                         done;
   logic                         err;
   logic [3:0]                   dbg_state;

   modport master (
      output load_req, load_slot, cfg_update, mask_enable, mask_rotate, mask_2x, rom_data,
      input  rom_addr, rom_rd, cmd_wr, cmd_out, busy, done, err, dbg_state
   );

   modport slave (
      input  load_req, load_slot, cfg_update, mask_enable, mask_rotate, mask_2x, rom_data,
      output rom_addr, rom_rd, cmd_wr, cmd_out, busy, done, err, dbg_state
   );
endinterface

// File: rtl/shadowmask_loader.sv
// Replays a ROM-stored mask definition as the mode/vmax/hmax/LUT command stream of the shadowmask,
// and re-sends the mode command alone when runtime mask settings change.
module shadowmask_loader #(
   parameter int SLOT_W     = 3,
   parameter int SLOT_SHIFT = 9,
   parameter int CMD_GAP    = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   shadowmask_loader_if.slave bus
);
   localparam int AW = SLOT_W + SLOT_SHIFT;
   localparam logic [3:0] GAP_RELOAD = 4'(CMD_GAP - 1);

   typedef enum logic [3:0] {IDLE, HDR0, HDR1, MODE, VMAX, HMAX, LUT, FIN, CFG} state_t;

   state_t            state_q, state_d;
   logic [3:0]        gap_q, gap_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [3:0]        vmax_q, vmax_d, hmax_q, hmax_d;
   logic [8:0]        n_q, n_d, lut_cnt_q, lut_cnt_d;
   logic [10:0]       entry_q, entry_d;
   logic              rd_dly_q, rd_dly_d;
   logic              pending_q, pending_d;
   logic [AW-1:0]     rom_addr_q, rom_addr_d;
   logic              rom_rd_q, rom_rd_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [15:0]       cmd_out_q, cmd_out_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [15:0]           mode_word;
   logic [10:0]           lut_word;
   logic [SLOT_SHIFT-1:0] lut_off;
   logic [8:0]            hdr_n;
   logic                  gap_zero;
   logic                  unused_rom_hi;

   assign mode_word     = {12'b0, bus.mask_enable, bus.mask_rotate, bus.mask_2x, 1'b0};
   // rd_dly_q marks the cycle rom_data holds the word read last cycle; use it directly or the held copy.
   assign lut_word      = rd_dly_q ? bus.rom_data[10:0] : entry_q;
   assign lut_off       = SLOT_SHIFT'(lut_cnt_q + 9'd2);
   assign hdr_n         = bus.rom_data[8:0];
   assign gap_zero      = (gap_q == 4'd0);
   assign unused_rom_hi = |bus.rom_data[15:11];

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         gap_q      <= '0;
         slot_q     <= '0;
         vmax_q     <= '0;
         hmax_q     <= '0;
         n_q        <= '0;
         lut_cnt_q  <= '0;
         entry_q    <= '0;
         rd_dly_q   <= 1'b0;
         pending_q  <= 1'b0;
         rom_addr_q <= '0;
         rom_rd_q   <= 1'b0;
         cmd_wr_q   <= 1'b0;
         cmd_out_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         slot_q     <= slot_d;
         vmax_q     <= vmax_d;
         hmax_q     <= hmax_d;
         n_q        <= n_d;
         lut_cnt_q  <= lut_cnt_d;
         entry_q    <= entry_d;
         rd_dly_q   <= rd_dly_d;
         pending_q  <= pending_d;
         rom_addr_q <= rom_addr_d;
         rom_rd_q   <= rom_rd_d;
         cmd_wr_q   <= cmd_wr_d;
         cmd_out_q  <= cmd_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      slot_d     = slot_q;
      vmax_d     = vmax_q;
      hmax_d     = hmax_q;
      n_d        = n_q;
      lut_cnt_d  = lut_cnt_q;
      entry_d    = rd_dly_q ? bus.rom_data[10:0] : entry_q;
      rd_dly_d   = rom_rd_q;
      pending_d  = pending_q | (bus.cfg_update && state_q != IDLE && state_q != CFG);
      rom_addr_d = rom_addr_q;
      rom_rd_d   = 1'b0;
      cmd_wr_d   = 1'b0;
      cmd_out_d  = cmd_out_q;
      busy_d     = (state_q != IDLE);
      done_d     = 1'b0;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            // busy_q can still be high for the cycle after a lone mode command; requests then are dropped.
            if (!busy_q && bus.load_req) begin
               state_d    = HDR0;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               pending_d  = 1'b0;
               slot_d     = bus.load_slot;
               lut_cnt_d  = '0;
               rom_rd_d   = 1'b1;
               rom_addr_d = {bus.load_slot, {SLOT_SHIFT{1'b0}}};
            end else if (!busy_q && bus.cfg_update) begin
               state_d = CFG;
               busy_d  = 1'b1;
               gap_d   = '0;
            end
         end
         HDR0: begin
            rom_rd_d   = 1'b1;
            rom_addr_d = {slot_q, SLOT_SHIFT'(1)};
            state_d    = HDR1;
         end
         HDR1: begin
            vmax_d  = bus.rom_data[7:4];
            hmax_d  = bus.rom_data[3:0];
            state_d = MODE;
         end
         MODE: begin
            if (hdr_n == 9'd0) begin
               n_d   = '0;
               err_d = 1'b1;
            end else if (hdr_n > 9'd256) begin
               n_d   = 9'd256;
               err_d = 1'b1;
            end else begin
               n_d = hdr_n;
            end
            cmd_wr_d  = 1'b1;
            cmd_out_d = mode_word;
            gap_d     = GAP_RELOAD;
            state_d   = VMAX;
         end
         VMAX: begin
            if (gap_zero) begin
               cmd_wr_d  = 1'b1;
               cmd_out_d = {3'b001, 9'b0, vmax_q};
               gap_d     = GAP_RELOAD;
               state_d   = HMAX;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         HMAX: begin
            if (gap_zero) begin
               cmd_wr_d  = 1'b1;
               cmd_out_d = {3'b010, 9'b0, hmax_q};
               gap_d     = GAP_RELOAD;
               state_d   = (n_q == 9'd0) ? FIN : LUT;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         LUT: begin
            if (gap_zero) begin
               cmd_wr_d  = 1'b1;
               cmd_out_d = {5'b01100, lut_word};
               gap_d     = GAP_RELOAD;
               lut_cnt_d = lut_cnt_q + 9'd1;
               if (lut_cnt_q + 9'd1 == n_q) state_d = FIN;
            end else begin
               gap_d = gap_q - 4'd1;
               // Fetch the next entry the cycle after the previous command, CMD_GAP-1 ahead of its use.
               if (gap_q == GAP_RELOAD) begin
                  rom_rd_d   = 1'b1;
                  rom_addr_d = {slot_q, lut_off};
               end
            end
         end
         FIN: begin
            if (gap_zero) begin
               done_d    = 1'b1;
               pending_d = 1'b0;
               if (pending_q || bus.cfg_update) begin
                  state_d = CFG;
                  gap_d   = GAP_RELOAD;
                  busy_d  = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         CFG: begin
            if (gap_zero) begin
               cmd_wr_d  = 1'b1;
               cmd_out_d = mode_word;
               busy_d    = 1'b1;
               state_d   = IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rom_addr  = rom_addr_q;
   assign bus.rom_rd    = rom_rd_q;
   assign bus.cmd_wr    = cmd_wr_q;
   assign bus.cmd_out   = cmd_out_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_shadowmask_loader.sv
// Directed bench for shadowmask_loader: one CMD_GAP=4 instance and one CMD_GAP=3 instance on a shared clock.
module tb_shadowmask_loader;
   logic clk_sys;
   logic reset;
   int   cyc;
   int   sel;
   int   n_pass, n_fail, n_total;

   logic [15:0] rom [0:4095];

   shadowmask_loader_if #(.SLOT_W(3), .SLOT_SHIFT(9)) ifa ();
   shadowmask_loader_if #(.SLOT_W(3), .SLOT_SHIFT(9)) ifb ();

   shadowmask_loader #(.SLOT_W(3), .SLOT_SHIFT(9), .CMD_GAP(4)) dut_a (
      .clk_sys(clk_sys), .reset(reset), .bus(ifa));
   shadowmask_loader #(.SLOT_W(3), .SLOT_SHIFT(9), .CMD_GAP(3)) dut_b (
      .clk_sys(clk_sys), .reset(reset), .bus(ifb));

   // clock / reset
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;
   initial cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // ROM model: data appears one cycle after the strobe, junk otherwise
   always @(posedge clk_sys) begin
      ifa.rom_data <= ifa.rom_rd ? rom[ifa.rom_addr] : 16'hDEAD;
      ifb.rom_data <= ifb.rom_rd ? rom[ifb.rom_addr] : 16'hDEAD;
   end

   // observation of the selected instance
   logic        m_cmd_wr, m_rom_rd, m_done, m_busy, m_err;
   logic [15:0] m_cmd_out;
   logic [11:0] m_rom_addr;
   assign m_cmd_wr   = (sel == 0) ? ifa.cmd_wr   : ifb.cmd_wr;
   assign m_cmd_out  = (sel == 0) ? ifa.cmd_out  : ifb.cmd_out;
   assign m_rom_rd   = (sel == 0) ? ifa.rom_rd   : ifb.rom_rd;
   assign m_rom_addr = (sel == 0) ? ifa.rom_addr : ifb.rom_addr;
   assign m_done     = (sel == 0) ? ifa.done     : ifb.done;
   assign m_busy     = (sel == 0) ? ifa.busy     : ifb.busy;
   assign m_err      = (sel == 0) ? ifa.err      : ifb.err;

   logic [15:0] cmd_v[$];
   int          cmd_t[$];
   logic [11:0] rd_a[$];
   int          rd_t[$];
   int          done_t[$];
   logic        busy_h[$];
   logic        err_h[$];

   always @(negedge clk_sys) begin
      if (m_cmd_wr) begin cmd_v.push_back(m_cmd_out); cmd_t.push_back(cyc); end
      if (m_rom_rd) begin rd_a.push_back(m_rom_addr); rd_t.push_back(cyc); end
      if (m_done) done_t.push_back(cyc);
      busy_h.push_back(m_busy);
      err_h.push_back(m_err);
   end

   // driver tasks
   task automatic tick();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic clear_log();
      cmd_v.delete(); cmd_t.delete(); rd_a.delete(); rd_t.delete();
      done_t.delete(); busy_h.delete(); err_h.delete();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_mode(input logic en, input logic rot, input logic x2);
      ifa.mask_enable = en; ifa.mask_rotate = rot; ifa.mask_2x = x2;
      ifb.mask_enable = en; ifb.mask_rotate = rot; ifb.mask_2x = x2;
   endtask

   task automatic pulse_load(input logic [2:0] slot, output int t0);
      tick();
      clear_log();
      if (sel == 0) begin ifa.load_req = 1'b1; ifa.load_slot = slot; end
      else begin ifb.load_req = 1'b1; ifb.load_slot = slot; end
      t0 = cyc;
      tick();
      ifa.load_req = 1'b0;
      ifb.load_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 3000; i++) begin
         if (!m_busy) break;
         tick();
      end
      chk({tag, " idle_timeout"}, 32'(i < 3000), 32'd1);
      repeat (8) tick();
   endtask

   // scoreboard for one full load
   task automatic check_load(input string tag, input int t0, input int g, input int slot,
                             input logic [3:0] vm, input logic [3:0] hm, input logic [15:0] mode_w,
                             input int n_used, input logic err_exp,
                             input logic has_extra, input logic [15:0] extra_w);
      logic [15:0] exp_q[$];
      int base, ncmd, done_exp, nc, nr;
      base = slot << 9;
      ncmd = 3 + n_used;
      done_exp = t0 + 4 + ncmd * g;
      exp_q.push_back(mode_w);
      exp_q.push_back(16'h2000 | 16'(vm));
      exp_q.push_back(16'h4000 | 16'(hm));
      for (int k = 0; k < n_used; k++) exp_q.push_back(16'h6000 | (rom[base + 2 + k] & 16'h07FF));
      if (has_extra) exp_q.push_back(extra_w);

      chk({tag, " cmd_count"}, cmd_v.size(), exp_q.size());
      nc = (cmd_v.size() < exp_q.size()) ? cmd_v.size() : exp_q.size();
      for (int i = 0; i < nc; i++) begin
         chk($sformatf("%s cmd%0d", tag, i), cmd_v[i], exp_q[i]);
         if (i < ncmd) chk($sformatf("%s cmd%0d_time", tag, i), cmd_t[i], t0 + 4 + i * g);
         else chk({tag, " extra_mode_time"}, cmd_t[i], done_exp + g);
      end

      chk({tag, " done_count"}, done_t.size(), 1);
      if (done_t.size() > 0) chk({tag, " done_time"}, done_t[0], done_exp);

      chk({tag, " busy_t0p1"}, busy_h[0], 1'b1);
      chk({tag, " err_t0p1"}, err_h[0], 1'b0);
      chk({tag, " busy_before_done"}, busy_h[done_exp - 1 - (t0 + 1)], 1'b1);
      chk({tag, " busy_at_done"}, busy_h[done_exp - (t0 + 1)], has_extra);
      if (has_extra) begin
         chk({tag, " busy_at_extra"}, busy_h[done_exp + g - (t0 + 1)], 1'b1);
         chk({tag, " busy_after_extra"}, busy_h[done_exp + g + 1 - (t0 + 1)], 1'b0);
      end
      chk({tag, " err_final"}, m_err, err_exp);

      chk({tag, " rd_count"}, rd_a.size(), 2 + n_used);
      nr = (rd_a.size() < 2 + n_used) ? rd_a.size() : 2 + n_used;
      for (int i = 0; i < nr; i++) begin
         chk($sformatf("%s rd%0d_addr", tag, i), rd_a[i], base + i);
         if (i < 2) chk($sformatf("%s rd%0d_time", tag, i), rd_t[i], t0 + 1 + i);
         else chk($sformatf("%s rd%0d_time", tag, i), rd_t[i], t0 + 4 + (i + 1) * g - (g - 1));
      end
   endtask

   initial begin
      int t0, t, i;
      n_pass = 0; n_fail = 0; n_total = 0; sel = 0;
      reset = 1'b1;
      ifa.load_req = 1'b0; ifa.load_slot = '0; ifa.cfg_update = 1'b0;
      ifb.load_req = 1'b0; ifb.load_slot = '0; ifb.cfg_update = 1'b0;
      set_mode(1'b1, 1'b0, 1'b1);

      for (int a = 0; a < 4096; a++) rom[a] = 16'h0000;
      // slot 2: 3 entries
      rom[12'h400] = 16'h0053; rom[12'h401] = 16'h0003;
      rom[12'h402] = 16'h07FF; rom[12'h403] = 16'h0400; rom[12'h404] = 16'h00AA;
      // slot 1: N=0, ignored bits set
      rom[12'h200] = 16'hFF21; rom[12'h201] = 16'hFE00;
      // slot 3: N=300, entries carry junk in the ignored bits
      rom[12'h600] = 16'h0077; rom[12'h601] = 16'h012C;
      for (int k = 0; k < 300; k++) rom[12'h602 + k] = 16'(k * 37 + 5) | 16'hF800;
      // slot 4: small load, only used as an ignored request
      rom[12'h800] = 16'h0011; rom[12'h801] = 16'h0005;
      // slot 5: N=256 exactly
      rom[12'hA00] = 16'h0034; rom[12'hA01] = 16'h0100;
      for (int k = 0; k < 256; k++) rom[12'hA02 + k] = 16'h0300 + 16'(k);

      // reset state
      repeat (3) tick();
      chk("rst busy", ifa.busy, 1'b0);
      chk("rst cmd_wr", ifa.cmd_wr, 1'b0);
      chk("rst rom_rd", ifa.rom_rd, 1'b0);
      chk("rst cmd_out", ifa.cmd_out, 16'h0000);
      reset = 1'b0;
      repeat (2) tick();
      chk("post_rst done", ifa.done, 1'b0);
      chk("post_rst err", ifa.err, 1'b0);

      // basic load of slot 2
      pulse_load(3'd2, t0);
      wait_idle("slot2");
      check_load("slot2", t0, 4, 2, 4'h5, 4'h3, 16'h000A, 3, 1'b0, 1'b0, 16'h0);

      // N=0: header only, err set
      pulse_load(3'd1, t0);
      wait_idle("n0");
      check_load("n0", t0, 4, 1, 4'h2, 4'h1, 16'h000A, 0, 1'b1, 1'b0, 16'h0);
      chk("n0 err_sticky", m_err, 1'b1);

      // N=256 exactly: no clamp, err cleared by this load
      pulse_load(3'd5, t0);
      wait_idle("n256");
      check_load("n256", t0, 4, 5, 4'h3, 4'h4, 16'h000A, 256, 1'b0, 1'b0, 16'h0);

      // N=300: clamped to 256, err set
      pulse_load(3'd3, t0);
      wait_idle("n300");
      check_load("n300", t0, 4, 3, 4'h7, 4'h7, 16'h000A, 256, 1'b1, 1'b0, 16'h0);

      // cfg_update in IDLE: single mode command two cycles later, no done
      set_mode(1'b1, 1'b1, 1'b0);
      tick();
      clear_log();
      ifa.cfg_update = 1'b1;
      t = cyc;
      tick();
      ifa.cfg_update = 1'b0;
      repeat (10) tick();
      chk("cfg cmd_count", cmd_v.size(), 1);
      if (cmd_v.size() > 0) begin
         chk("cfg cmd", cmd_v[0], 16'h000C);
         chk("cfg cmd_time", cmd_t[0], t + 2);
      end
      chk("cfg busy_t1", busy_h[0], 1'b1);
      chk("cfg busy_t2", busy_h[1], 1'b1);
      chk("cfg busy_t3", busy_h[2], 1'b0);
      chk("cfg done_count", done_t.size(), 0);
      chk("cfg rd_count", rd_a.size(), 0);

      // cfg_update and an ignored load_req during a load of slot 2
      set_mode(1'b1, 1'b0, 1'b1);
      pulse_load(3'd2, t0);
      repeat (4) tick();
      set_mode(1'b1, 1'b1, 1'b0);
      ifa.cfg_update = 1'b1;
      tick();
      ifa.cfg_update = 1'b0;
      tick();
      ifa.load_req = 1'b1;
      ifa.load_slot = 3'd4;
      tick();
      ifa.load_req = 1'b0;
      wait_idle("midcfg");
      check_load("midcfg", t0, 4, 2, 4'h5, 4'h3, 16'h000A, 3, 1'b0, 1'b1, 16'h000C);

      // reset at the 10th LUT command of a long load
      set_mode(1'b1, 1'b0, 1'b1);
      pulse_load(3'd3, t0);
      for (i = 0; i < 600 && cmd_v.size() < 13; i++) tick();
      chk("midrst reach_lut10", 32'(cmd_v.size()), 32'd13);
      chk("midrst err_before", ifa.err, 1'b1);
      reset = 1'b1;
      #1;
      chk("midrst cmd_wr", ifa.cmd_wr, 1'b0);
      chk("midrst cmd_out", ifa.cmd_out, 16'h0000);
      chk("midrst rom_rd", ifa.rom_rd, 1'b0);
      chk("midrst rom_addr", ifa.rom_addr, 12'h000);
      chk("midrst busy", ifa.busy, 1'b0);
      chk("midrst done", ifa.done, 1'b0);
      chk("midrst err", ifa.err, 1'b0);
      chk("midrst state", ifa.dbg_state, 4'd0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      pulse_load(3'd2, t0);
      wait_idle("afterrst");
      check_load("afterrst", t0, 4, 2, 4'h5, 4'h3, 16'h000A, 3, 1'b0, 1'b0, 16'h0);

      // CMD_GAP=3 instance, same slot 2 load
      sel = 1;
      repeat (2) tick();
      pulse_load(3'd2, t0);
      wait_idle("gap3");
      check_load("gap3", t0, 3, 2, 4'h5, 4'h3, 16'h000A, 3, 1'b0, 1'b0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
